bus_initiator: RTL

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator.sv | 92 +++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding command-to-memory-bus initiator with a bounded wait-for-ready timeout.
module bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        write_q, write_d, error_q, error_d;
    logic [7:0]  cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        write_d = write_q;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                wdata_d = cmd_wdata;
                wstrb_d = cmd_write ? cmd_wstrb : 4'h0;
                write_d = cmd_write;
                cnt_d   = 8'h0;
                state_d = BUS;
            end
            BUS: if (mem_ready) begin
                rdata_d = write_q ? 32'h0 : mem_rdata;
                error_d = 1'b0;
                state_d = RESP;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                rdata_d = 32'h0;
                error_d = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'h1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cmd_ready = state_q == IDLE;
    assign mem_valid = state_q == BUS;
    assign rsp_valid = state_q == RESP;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
endmodule
